// File: rtl/counter_seq_pkg.sv
// Shared definitions for the run/stop/clear display counter:
// FSM state encoding, button indices and the active-low seven-segment glyph table.
package counter_seq_pkg;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Button positions in the conditioned pulse vector
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;
    localparam int NUM_BTN   = 3;

    // Segment glyphs {g,f,e,d,c,b,a}, active-low, hex digits 0-F
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        return SEG_GLYPH[value];
    endfunction

endpackage

// File: rtl/m_btn_cond.sv
// Raw push-button conditioner: 2-flop synchronizer, optional debounce filter
// and a registered rising-edge detector producing a 1-cycle pulse.
// Optional feature macro: DEBOUNCE_EN (adds a DB_CYCLES stable-time filter).
module m_btn_cond #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic ck,
    input  logic nres,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic hist_q;
    logic pulse_q;

    // Two-flop synchronizer; resets high so a button held through reset looks already pressed
    always_ff @(posedge ck or negedge nres) begin
        if (!nres) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] db_cnt_q;
    logic          level_q;

    // Filtered level follows the input only after DB_CYCLES consecutive differing samples
    always_ff @(posedge ck or negedge nres) begin
        if (!nres) begin
            db_cnt_q <= '0;
            level_q  <= 1'b1;
        end else if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_cnt_q <= '0;
                level_q  <= sync2_q;
            end else begin
                db_cnt_q <= db_cnt_q + CW'(1);
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    // Registered rising-edge detector; history resets high so no pulse comes out of reset
    always_ff @(posedge ck or negedge nres) begin
        if (!nres) begin
            hist_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= level;
            pulse_q <= level & ~hist_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/m_counter_sequencer.sv
// Run/stop/clear controller for a 4-bit display counter with prescaled count
// steps and one seven-segment digit. Buttons are conditioned by m_btn_cond.
// Optional feature macro: DEBOUNCE_EN (button debounce, DB_CYCLES stable time).
module m_counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int         DIV       = 50_000_000,
    parameter logic [3:0] MAX_CNT   = 4'd9,
    parameter bit         WRAP      = 1'b1,
    parameter int         DB_CYCLES = 500_000
) (
    input  logic       ck,
    input  logic       nres,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] q,
    output logic       cnt_tick,
    output logic       running,
    output logic       done,
    output logic [6:0] seg
);

    localparam int            PW       = $clog2(DIV);
    localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;

    state_e        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [PW-1:0] psc_q, psc_d;
    logic          tick_q, tick_d;
    logic          running_q;
    logic          done_q;

    assign btn_raw[BTN_START] = start;
    assign btn_raw[BTN_STOP]  = stop;
    assign btn_raw[BTN_CLEAR] = clear;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        m_btn_cond #(
            .DB_CYCLES(DB_CYCLES)
        ) u_btn_cond (
            .ck     (ck),
            .nres   (nres),
            .btn_i  (btn_raw[gi]),
            .pulse_o(btn_pulse[gi])
        );
    end

    wire start_p = btn_pulse[BTN_START];
    wire stop_p  = btn_pulse[BTN_STOP];
    wire clear_p = btn_pulse[BTN_CLEAR];

    // Next-state logic: clear beats stop beats start; stop beats a coincident tick
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        psc_d   = psc_q;
        tick_d  = 1'b0;
        if (clear_p) begin
            state_d = ST_IDLE;
            count_d = 4'd0;
            psc_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!stop_p && start_p) begin
                        state_d = ST_RUN;
                        psc_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (stop_p) begin
                        state_d = ST_PAUSE;
                    end else if (psc_q == PSC_LAST) begin
                        psc_d  = '0;
                        tick_d = 1'b1;
                        if (count_q != MAX_CNT) begin
                            count_d = count_q + 4'd1;
                        end else if (WRAP) begin
                            count_d = 4'd0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        psc_d = psc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!stop_p && start_p) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and registered status outputs
    always_ff @(posedge ck or negedge nres) begin
        if (!nres) begin
            state_q   <= ST_IDLE;
            count_q   <= 4'd0;
            psc_q     <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            psc_q     <= psc_d;
            tick_q    <= tick_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign q        = count_q;
    assign cnt_tick = tick_q;
    assign running  = running_q;
    assign done     = done_q;
    assign seg      = seg_decode(count_q);

endmodule

// File: tb/tb_m_counter_sequencer.sv
// Self-checking bench: two instances (WRAP=1 and WRAP=0) share the button
// stimulus and are compared every cycle against a behavioural model.
module tb_m_counter_sequencer;

    localparam int DIV  = 4;
    localparam int MAXC = 9;
    localparam int DB   = 8;
`ifdef DEBOUNCE_EN
    localparam int LAT  = 3 + DB;
    localparam int HOLD = DB + 2;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 1;
`endif

    logic ck = 1'b0;
    logic nres = 1'b0;
    logic b_start = 1'b0;
    logic b_stop = 1'b0;
    logic b_clear = 1'b0;

    logic [3:0] q0, q1;
    logic       t0, t1, r0, r1, d0, d1;
    logic [6:0] s0, s1;

    int vectors = 0;
    int miscompares = 0;

    always #5 ck = ~ck;

    m_counter_sequencer #(.DIV(DIV), .MAX_CNT(4'(MAXC)), .WRAP(1'b1), .DB_CYCLES(DB)) dut_wrap (
        .ck(ck), .nres(nres), .start(b_start), .stop(b_stop), .clear(b_clear),
        .q(q0), .cnt_tick(t0), .running(r0), .done(d0), .seg(s0)
    );

    m_counter_sequencer #(.DIV(DIV), .MAX_CNT(4'(MAXC)), .WRAP(1'b0), .DB_CYCLES(DB)) dut_stop (
        .ck(ck), .nres(nres), .start(b_start), .stop(b_stop), .clear(b_clear),
        .q(q1), .cnt_tick(t1), .running(r1), .done(d1), .seg(s1)
    );

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
    mstate_t  m_st  [2];
    int       m_q   [2];
    int       m_psc [2];
    bit       m_tick[2];
    bit [3:0] m_hist[3];   // raw samples, bit0 = most recent edge
    bit       m_lvl [3];
    int       m_dbc [3];
    bit [2:0] m_lh  [3];   // filtered level history, bit0 = most recent edge

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
           12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
        endcase
    endfunction

    function automatic bit raw(input int b);
        return (b == 0) ? b_start : (b == 1) ? b_stop : b_clear;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = M_IDLE; m_q[i] = 0; m_psc[i] = 0; m_tick[i] = 0;
        end
        for (int b = 0; b < 3; b++) begin
            m_hist[b] = 4'b1111; m_lvl[b] = 1'b1; m_dbc[b] = 0; m_lh[b] = 3'b111;
        end
    endtask

    task automatic model_step();
        bit f[3];
        for (int b = 0; b < 3; b++) begin
`ifdef DEBOUNCE_EN
            f[b] = m_lh[b][1] & ~m_lh[b][2];
            if (m_hist[b][1] != m_lvl[b]) begin
                m_dbc[b]++;
                if (m_dbc[b] == DB) begin m_lvl[b] = ~m_lvl[b]; m_dbc[b] = 0; end
            end else m_dbc[b] = 0;
            m_lh[b] = {m_lh[b][1:0], m_lvl[b]};
`else
            f[b] = m_hist[b][2] & ~m_hist[b][3];
`endif
            m_hist[b] = {m_hist[b][2:0], raw(b)};
        end
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 0;
            if (f[2]) begin
                m_st[i] = M_IDLE; m_q[i] = 0; m_psc[i] = 0;
            end else if (m_st[i] == M_RUN) begin
                if (f[1]) m_st[i] = M_PAUSE;
                else if (m_psc[i] == DIV - 1) begin
                    m_psc[i] = 0; m_tick[i] = 1;
                    if (m_q[i] < MAXC) m_q[i]++;
                    else if (i == 0) m_q[i] = 0;
                    else m_st[i] = M_DONE;
                end else m_psc[i]++;
            end else if ((m_st[i] == M_IDLE || m_st[i] == M_PAUSE) && !f[1] && f[0]) begin
                if (m_st[i] == M_IDLE) m_psc[i] = 0;
                m_st[i] = M_RUN;
            end
        end
    endtask

    function automatic logic [13:0] expv(input int i);
        return {4'(m_q[i]), m_tick[i], m_st[i] == M_RUN, m_st[i] == M_DONE, glyph(m_q[i])};
    endfunction

    function automatic logic [13:0] obs(input int i);
        return (i == 0) ? {q0, t0, r0, d0, s0} : {q1, t1, r1, d1, s1};
    endfunction

    // One clock edge for DUTs and model; returns 1 time unit after the edge
    task automatic adv();
        @(posedge ck);
        if (!nres) model_reset(); else model_step();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        $display("[%0t] reset: power-on reset values", $time);
        nres = 0; b_start = 0; b_stop = 0; b_clear = 0;
        model_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs(i) !== 14'b0000_000_1000000) begin
                miscompares++; $display("FAIL reset_init dut%0d: got %b want %b", i, obs(i), 14'b0000_000_1000000);
            end
        end
        adv(); adv();
        nres = 1;
        for (int c = 0; c < 4; c++) begin
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL reset_idle dut%0d: got %b want %b", i, obs(i), expv(i)); end
            end
        end
    endtask

    task automatic test_start();
        $display("[%0t] start: press start in IDLE, latency and tick spacing", $time);
        for (int c = 1; c <= 30; c++) begin
            b_start = (c <= HOLD);
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL start dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
            if (c == LAT) begin
                vectors++;
                if (r0 !== 1'b0) begin miscompares++; $display("FAIL start_early: running=%b want 0", r0); end
            end
            if (c == LAT + 1) begin
                vectors++;
                if (r0 !== 1'b1) begin miscompares++; $display("FAIL start_latency: running=%b want 1", r0); end
            end
            if (c == LAT + 1 + DIV) begin
                vectors++;
                if (t0 !== 1'b1 || q0 !== 4'd1) begin miscompares++; $display("FAIL first_tick: tick=%b q=%0d want tick=1 q=1", t0, q0); end
            end
        end
    endtask

    task automatic test_wrap();
        $display("[%0t] wrap: run past MAX_CNT, WRAP=1 wraps, WRAP=0 stops in DONE", $time);
        for (int c = 1; c <= 40; c++) begin
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL wrap dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
        end
        vectors++;
        if (d1 !== 1'b1 || q1 !== 4'd9 || r0 !== 1'b1) begin
            miscompares++; $display("FAIL wrap_end: done1=%b q1=%0d run0=%b want 1 9 1", d1, q1, r0);
        end
        for (int c = 1; c <= LAT + 4 + HOLD; c++) begin
            b_start = (c <= HOLD);
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL done_start dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
        end
        vectors++;
        if (d1 !== 1'b1 || r1 !== 1'b0) begin miscompares++; $display("FAIL done_ignores_start: done=%b run=%b want 1 0", d1, r1); end
        for (int c = 1; c <= LAT + 2 + HOLD; c++) begin
            b_clear = (c <= HOLD);
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL done_clear dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
        end
        vectors++;
        if (q0 !== 4'd0 || q1 !== 4'd0 || d1 !== 1'b0) begin miscompares++; $display("FAIL clear_idle: q0=%0d q1=%0d done1=%b want 0 0 0", q0, q1, d1); end
    endtask

    task automatic test_pause();
        int pressed_at;
        $display("[%0t] pause: stop at q=3 then resume", $time);
        pressed_at = -1;
        for (int c = 1; c <= 120; c++) begin
            b_start = (c <= HOLD) || (c > 70 && c <= 70 + HOLD);
            b_stop  = (pressed_at > 0) && (c < pressed_at + HOLD);
            adv();
            if (pressed_at < 0 && m_q[0] == 3 && m_tick[0]) pressed_at = c + 1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL pause dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
            if (c == 70) begin
                vectors++;
                if (r0 !== 1'b0 || q0 !== 4'(m_q[0]) || m_st[0] != M_PAUSE) begin
                    miscompares++; $display("FAIL paused: run=%b q=%0d want run=0 q=%0d", r0, q0, m_q[0]);
                end
            end
        end
    endtask

    task automatic test_priority();
        int fired;
        $display("[%0t] priority: clear>stop>start", $time);
        b_start = 0; b_stop = 0;
        fired = -1;
        for (int c = 1; c <= LAT + 2 + HOLD; c++) begin
            b_clear = (c <= HOLD);
            adv();
        end
        model_step_check_all: for (int c = 1; c <= 100; c++) begin
            b_start = (c <= HOLD);
            b_stop  = (fired > 0) && (c < fired + HOLD);
            b_clear = (fired > 0) && (c < fired + HOLD);
            if (fired > 0) b_start = b_start || (c < fired + HOLD);
            adv();
            if (fired < 0 && m_q[0] == 5 && m_tick[0]) fired = c + DIV - LAT + 1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL prio_all dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
            if (fired > 0 && c == fired + LAT + 3) break;
        end
        vectors++;
        if (q0 !== 4'd0 || r0 !== 1'b0 || d0 !== 1'b0) begin miscompares++; $display("FAIL prio_clear: q=%0d run=%b want q=0 run=0", q0, r0); end
        b_start = 0; b_stop = 0; b_clear = 0;
        for (int c = 1; c <= 2 * LAT + 14 + 2 * HOLD; c++) begin
            b_start = (c <= HOLD) || (c > LAT + 8 && c <= LAT + 8 + HOLD);
            b_stop  = (c > LAT + 8 && c <= LAT + 8 + HOLD);
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL prio_stop dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
        end
        vectors++;
        if (r0 !== 1'b0 || d0 !== 1'b0 || m_st[0] != M_PAUSE) begin miscompares++; $display("FAIL prio_pause: run=%b done=%b want 0 0", r0, d0); end
        b_start = 0; b_stop = 0;
    endtask

    task automatic test_held_reset();
        $display("[%0t] held start across reset release, then async reset mid-run", $time);
        b_start = 1;
        #2 nres = 0;
        adv(); adv();
        nres = 1;
        for (int c = 1; c <= LAT + 8; c++) begin
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL held dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
        end
        vectors++;
        if (r0 !== 1'b0) begin miscompares++; $display("FAIL held_no_run: running=%b want 0", r0); end
        b_start = 0;
        for (int c = 1; c <= 80 && !(m_q[0] == 5 && m_psc[0] == 1); c++) begin
            b_start = (c > 2 * HOLD + 2 && c <= 3 * HOLD + 2);
            adv();
        end
        vectors++;
        if (q0 !== 4'd5 || r0 !== 1'b1) begin miscompares++; $display("FAIL midrun_setup: q=%0d run=%b want 5 1", q0, r0); end
        #2 nres = 0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs(i) !== 14'b0000_000_1000000) begin miscompares++; $display("FAIL async_reset dut%0d: got %b want %b", i, obs(i), 14'b0000_000_1000000); end
        end
        adv();
        nres = 1;
    endtask

`ifdef DEBOUNCE_EN
    task automatic test_bounce();
        $display("[%0t] debounce: 3-cycle bounces then stable press", $time);
        for (int c = 1; c <= 60; c++) begin
            b_start = (c <= 18) ? (((c - 1) / 3) % 2 == 0) : (c <= 30);
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL bounce dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
            if (c == 22) begin
                vectors++;
                if (r0 !== 1'b0) begin miscompares++; $display("FAIL bounce_ignored: running=%b want 0", r0); end
            end
        end
        vectors++;
        if (r0 !== 1'b1) begin miscompares++; $display("FAIL stable_press: running=%b want 1", r0); end
    endtask
`endif

    task automatic test_random();
        $display("[%0t] random: button noise with occasional resets", $time);
        for (int c = 1; c <= 2000; c++) begin
            if ($urandom_range(5) == 0)  b_start = ~b_start;
            if ($urandom_range(19) == 0) b_stop  = ~b_stop;
            if ($urandom_range(59) == 0) b_clear = ~b_clear;
            nres = ($urandom_range(499) != 0);
            adv();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== expv(i)) begin miscompares++; $display("FAIL random dut%0d cyc %0d: got %b want %b", i, c, obs(i), expv(i)); end
            end
        end
        nres = 1; b_start = 0; b_stop = 0; b_clear = 0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_wrap();
        test_pause();
        test_priority();
        test_held_reset();
`ifdef DEBOUNCE_EN
        test_bounce();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
